aes_key_expansion_192: RTL and testbench

- Iterative AES-192 key schedule (FIPS-197): takes a 192-bit cipher key and streams the 13 128-bit round keys RK0..RK12, one per clock.
- Sits between key load logic and the AES-192 round datapath, which consumes `subkey` while `rdy` is high.

---
 rtl/aes_pkg.sv | 70 +++++++
 rtl/aes_sbox.sv | 11 +
 rtl/aes_key_expansion_192.sv | 131 +++++++++++++
 tb/tb_aes_key_expansion_192.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared types, constants and word-level helpers for the AES-192 key schedule.
package aes_pkg;

    localparam int NK     = 6;
    localparam int NR     = 12;
    localparam int NUM_RK = 13;

    // Counter value while the final round key is on the output.
    localparam logic [3:0] LAST_RK = 4'd12;

    typedef logic [31:0] word_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Forward S-box, row-major, entry 0x00 in the top byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox_byte(input logic [7:0] b);
        logic [10:0] base;
        base = 11'd2047 - {b, 3'b000};
        return SBOX_TABLE[base -: 8];
    endfunction

    function automatic word_t rot_word(input word_t w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic word_t sub_word(input word_t w);
        return {sbox_byte(w[31:24]), sbox_byte(w[23:16]),
                sbox_byte(w[15:8]),  sbox_byte(w[7:0])};
    endfunction

    // Round constant byte, indexed by word index / NK (1..8 are used).
    function automatic logic [7:0] rcon_byte(input logic [5:0] idx);
        logic [7:0] rc;
        case (idx)
            6'd1:    rc = 8'h01;
            6'd2:    rc = 8'h02;
            6'd3:    rc = 8'h04;
            6'd4:    rc = 8'h08;
            6'd5:    rc = 8'h10;
            6'd6:    rc = 8'h20;
            6'd7:    rc = 8'h40;
            6'd8:    rc = 8'h80;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational forward AES S-box for one byte.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] din,
    output logic [7:0] dout
);

    assign dout = sbox_byte(din);

endmodule

// File: rtl/aes_key_expansion_192.sv
// Iterative AES-192 key schedule: streams RK0..RK12, one round key per clock.
// A 6-word window w[i-6..i-1] advances by 4 words per cycle; one shared
// SubWord serves whichever of the 4 new words sits on a multiple of 6.
module aes_key_expansion_192
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [191:0] short_key,
    output logic [127:0] subkey,
    output logic         rdy
);

    state_e       state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    word_t        win_q [6];
    word_t        win_d [6];
    logic [127:0] subkey_q, subkey_d;
    logic         rdy_q, rdy_d;

    logic [5:0]   wi_s;
    logic         sel0_s;
    logic         sel2_s;
    word_t        n0_plain_s;
    word_t        n1_plain_s;
    word_t        sub_in_s;
    word_t        sub_out_s;
    logic [5:0]   rc_idx_s;
    word_t        temp_s;
    word_t        n0_s, n1_s, n2_s, n3_s;

    // Locate the transformed position among the 4 new words and pick its SubWord input.
    always_comb begin
        wi_s       = 6'd6 + {cnt_q, 2'b00};
        sel0_s     = ((wi_s % 6'd6) == 6'd0);
        sel2_s     = (((wi_s + 6'd2) % 6'd6) == 6'd0);
        n0_plain_s = win_q[0] ^ win_q[5];
        n1_plain_s = win_q[1] ^ n0_plain_s;
        sub_in_s   = rot_word(sel0_s ? win_q[5] : n1_plain_s);
        rc_idx_s   = sel0_s ? (wi_s / 6'd6) : ((wi_s + 6'd2) / 6'd6);
    end

    genvar g;
    for (g = 0; g < 4; g++) begin : g_sbox
        aes_sbox u_sbox (
            .din  (sub_in_s[8*g +: 8]),
            .dout (sub_out_s[8*g +: 8])
        );
    end

    // Chain the four new words w[i..i+3], applying temp at the selected position.
    always_comb begin
        temp_s = sub_out_s ^ {rcon_byte(rc_idx_s), 24'h000000};
        n0_s   = win_q[0] ^ (sel0_s ? temp_s : win_q[5]);
        n1_s   = win_q[1] ^ n0_s;
        n2_s   = win_q[2] ^ (sel2_s ? temp_s : n1_s);
        n3_s   = win_q[3] ^ n2_s;
    end

    // Next-state, window, round-key and ready computation.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        win_d    = win_q;
        subkey_d = subkey_q;
        rdy_d    = rdy_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_RUN;
                    cnt_d    = 4'd0;
                    win_d[0] = short_key[191:160];
                    win_d[1] = short_key[159:128];
                    win_d[2] = short_key[127:96];
                    win_d[3] = short_key[95:64];
                    win_d[4] = short_key[63:32];
                    win_d[5] = short_key[31:0];
                    subkey_d = short_key[191:64];
                    rdy_d    = 1'b1;
                end else begin
                    rdy_d    = 1'b0;
                end
            end
            ST_RUN: begin
                if (cnt_q == LAST_RK) begin
                    // Final key stays on subkey; only rdy drops.
                    state_d = ST_IDLE;
                    rdy_d   = 1'b0;
                end else begin
                    subkey_d = {win_q[4], win_q[5], n0_s, n1_s};
                    win_d[0] = win_q[4];
                    win_d[1] = win_q[5];
                    win_d[2] = n0_s;
                    win_d[3] = n1_s;
                    win_d[4] = n2_s;
                    win_d[5] = n3_s;
                    cnt_d    = cnt_q + 4'd1;
                    rdy_d    = 1'b1;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                cnt_d    = 4'd0;
                subkey_d = 128'h0;
                rdy_d    = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 4'd0;
            win_q    <= '{default: 32'h0};
            subkey_q <= 128'h0;
            rdy_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            win_q    <= win_d;
            subkey_q <= subkey_d;
            rdy_q    <= rdy_d;
        end
    end

    assign subkey = subkey_q;
    assign rdy    = rdy_q;

endmodule

// File: tb/tb_aes_key_expansion_192.sv
// Self-checking bench for aes_key_expansion_192: FIPS-197 A.2 vectors,
// zero key, start hold, mid-run reset, ignored inputs and random keys.
module tb_aes_key_expansion_192;

    logic         clk;
    logic         reset;
    logic         start;
    logic [191:0] short_key;
    logic [127:0] subkey;
    logic         rdy;

    int n_checks;
    int n_pass;

    logic [127:0] exp_rk [13];
    logic [127:0] got_rk [13];

    localparam logic [191:0] KEY_A2 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;

    aes_key_expansion_192 dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .short_key (short_key),
        .subkey    (subkey),
        .rdy       (rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Independent reference: GF(2^8) arithmetic based S-box.
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = xtime(x);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl1(input logic [7:0] a);
        return {a[6:0], a[7]};
    endfunction

    function automatic logic [7:0] sbox_ref(input logic [7:0] b);
        logic [7:0] inv, s, r;
        inv = 8'h01;
        for (int i = 0; i < 254; i++) inv = gmul(inv, b);
        s = inv;
        r = inv;
        for (int i = 0; i < 4; i++) begin
            r = rotl1(r);
            s = s ^ r;
        end
        return s ^ 8'h63;
    endfunction

    task automatic compute_model(input logic [191:0] key);
        logic [31:0] w [52];
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < 6; i++) w[i] = key[191 - 32*i -: 32];
        rc = 8'h01;
        for (int i = 6; i < 52; i++) begin
            t = w[i-1];
            if (i % 6 == 0) begin
                t = {sbox_ref(t[23:16]), sbox_ref(t[15:8]), sbox_ref(t[7:0]), sbox_ref(t[31:24])}
                    ^ {rc, 24'h000000};
                rc = xtime(rc);
            end
            w[i] = w[i-6] ^ t;
        end
        for (int r = 0; r < 13; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // One full run from IDLE: 13 keys with rdy high, then rdy low holding RK12.
    task automatic run_key(input string tag, input logic [191:0] key, input bit hold_start);
        compute_model(key);
        short_key = key;
        start     = 1'b1;
        tick();
        if (!hold_start) start = 1'b0;
        for (int i = 0; i < 13; i++) begin
            got_rk[i] = subkey;
            check_val($sformatf("%s_rk%0d", tag, i), subkey, exp_rk[i]);
            check_val($sformatf("%s_rdy%0d", tag, i), {127'h0, rdy}, 128'h1);
            tick();
        end
        check_val($sformatf("%s_rdy_drop", tag), {127'h0, rdy}, 128'h0);
        check_val($sformatf("%s_hold_rk12", tag), subkey, exp_rk[12]);
        if (hold_start) begin
            tick();
            check_val($sformatf("%s_restart_rk0", tag), subkey, exp_rk[0]);
            check_val($sformatf("%s_restart_rdy", tag), {127'h0, rdy}, 128'h1);
            start = 1'b0;
            for (int i = 0; i < 13; i++) tick();
            check_val($sformatf("%s_restart_done", tag), {127'h0, rdy}, 128'h0);
        end
    endtask

    initial begin
        logic [191:0] rkey;
        n_checks  = 0;
        n_pass    = 0;
        reset     = 1'b1;
        start     = 1'b0;
        short_key = 192'h0;
        @(negedge clk);
        tick();
        check_val("reset_subkey", subkey, 128'h0);
        check_val("reset_rdy", {127'h0, rdy}, 128'h0);
        reset = 1'b0;

        // FIPS-197 A.2 key with hand-copied published round keys.
        run_key("a2", KEY_A2, 1'b0);
        check_val("a2_fips_rk0",  got_rk[0],  128'h8e73b0f7da0e6452c810f32b809079e5);
        check_val("a2_fips_rk1",  got_rk[1],  128'h62f8ead2522c6b7bfe0c91f72402f5a5);
        check_val("a2_fips_rk2",  got_rk[2],  128'hec12068e6c827f6b0e7a95b95c56fec2);
        check_val("a2_fips_rk12", got_rk[12], 128'he98ba06f448c773c8ecc720401002202);

        // Start held high: RK0 returns after one idle cycle.
        run_key("a2_hold", KEY_A2, 1'b1);

        // All-zero key.
        run_key("zero", 192'h0, 1'b0);
        check_val("zero_fips_rk1", got_rk[1], 128'h00000000000000006263636362636363);

        // Reset while RK5 is shown, then a fresh start.
        compute_model(KEY_A2);
        short_key = KEY_A2;
        start     = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check_val("rst_mid_rk5", subkey, exp_rk[5]);
        reset = 1'b1;
        start = 1'b1;
        tick();
        check_val("rst_mid_subkey", subkey, 128'h0);
        check_val("rst_mid_rdy", {127'h0, rdy}, 128'h0);
        reset = 1'b0;
        start = 1'b0;
        tick();
        check_val("rst_idle_rdy", {127'h0, rdy}, 128'h0);
        run_key("after_rst", KEY_A2, 1'b0);

        // Toggle start and change short_key from RK3 on: output must not change.
        rkey = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        compute_model(rkey);
        short_key = rkey;
        start     = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 13; i++) begin
            check_val($sformatf("ign_rk%0d", i), subkey, exp_rk[i]);
            check_val($sformatf("ign_rdy%0d", i), {127'h0, rdy}, 128'h1);
            if (i >= 3) begin
                short_key = ~rkey ^ {6{$urandom}};
                start     = (i < 11) ? i[0] : 1'b0;
            end
            tick();
        end
        check_val("ign_rdy_drop", {127'h0, rdy}, 128'h0);
        check_val("ign_hold_rk12", subkey, exp_rk[12]);
        tick();
        check_val("ign_idle_rdy", {127'h0, rdy}, 128'h0);

        // Random keys.
        for (int k = 0; k < 100; k++) begin
            rkey = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            run_key($sformatf("rnd%0d", k), rkey, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
